game_ctrl: RTL

Parametrised top-level game sequencer for the VGA shooter. It tracks the game phase, player health with post-hit invulnerability, the kill score, and enemy respawn requests. Unlike the fixed three-enemy controller, it supports N_ENEMY channels, a pause mode and configurable health and score widths. It gates the movement modules through update_en and feeds score, health and state to the renderer.

---
 rtl/game_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/game_ctrl.sv
// Game sequencer for the VGA shooter: phase FSM, health with post-hit invulnerability,
// saturating kill score and per-enemy respawn pulses. Define HIGH_SCORE_EN to keep a best-score register.
module game_ctrl #(
    parameter int N_ENEMY       = 3,
    parameter int HEALTH_W      = 3,
    parameter int MAX_HEALTH    = 3,
    parameter int SCORE_W       = 10,
    parameter int INVULN_FRAMES = 30
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                pause,
    input  logic                frame_tick,
    input  logic [N_ENEMY-1:0]  hit_vec,
    input  logic [N_ENEMY-1:0]  kill_vec,
    output logic [2:0]          state,
    output logic                update_en,
    output logic [HEALTH_W-1:0] health,
    output logic [SCORE_W-1:0]  score,
    output logic [N_ENEMY-1:0]  respawn_vec,
    output logic                invuln,
    output logic                game_end,
    output logic [SCORE_W-1:0]  high_score
);

    localparam int CNT_W = $clog2(N_ENEMY + 1);
    localparam int INV_W = $clog2(INVULN_FRAMES + 1);
    localparam int SUM_W = ((SCORE_W > CNT_W) ? SCORE_W : CNT_W) + 1;

    localparam logic [HEALTH_W-1:0] HEALTH_LOAD = HEALTH_W'(MAX_HEALTH);
    localparam logic [HEALTH_W-1:0] HEALTH_ONE  = HEALTH_W'(1);
    localparam logic [INV_W-1:0]    INV_LOAD    = INV_W'(INVULN_FRAMES);
    localparam logic [INV_W-1:0]    INV_ONE     = INV_W'(1);
    localparam logic [SCORE_W-1:0]  SCORE_MAX   = '1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PLAY  = 3'd1,
        ST_PAUSE = 3'd2,
        ST_HIT   = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    state_t              state_q;
    logic [HEALTH_W-1:0] health_q;
    logic [SCORE_W-1:0]  score_q;
    logic [SCORE_W-1:0]  score_d;
    logic [N_ENEMY-1:0]  respawn_q;
    logic [INV_W-1:0]    inv_cnt_q;
    logic                start_q;
    logic                pause_q;
    logic                update_en_q;
    logic                invuln_q;
    logic                game_end_q;

    logic                active_s;
    logic                start_rise_s;
    logic                pause_rise_s;
    logic                over_entry_s;
    logic [CNT_W-1:0]    kills_s;
    logic [SUM_W-1:0]    sum_s;

    function automatic logic [CNT_W-1:0] popcount(input logic [N_ENEMY-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_ENEMY; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    // Edge detects, kill counting and the saturating next score
    always_comb begin
        active_s     = (state_q == ST_PLAY) || (state_q == ST_HIT);
        start_rise_s = start & ~start_q;
        pause_rise_s = pause & ~pause_q;
        over_entry_s = (state_q == ST_PLAY) && (|hit_vec) && (health_q == HEALTH_ONE);
        // An enemy that both hit and died counts as a hit only
        kills_s      = popcount(kill_vec & ~hit_vec);
        sum_s        = SUM_W'(score_q) + SUM_W'(kills_s);
        if (sum_s > SUM_W'(SCORE_MAX)) begin
            score_d = SCORE_MAX;
        end else begin
            score_d = sum_s[SCORE_W-1:0];
        end
    end

    // Phase FSM with health, invulnerability timer, score, respawn and decoded flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            health_q    <= HEALTH_LOAD;
            score_q     <= '0;
            respawn_q   <= '0;
            inv_cnt_q   <= '0;
            start_q     <= 1'b0;
            pause_q     <= 1'b0;
            update_en_q <= 1'b0;
            invuln_q    <= 1'b0;
            game_end_q  <= 1'b0;
        end else begin
            start_q <= start;
            pause_q <= pause;
            if (active_s) begin
                respawn_q <= kill_vec | hit_vec;
                score_q   <= score_d;
            end else begin
                respawn_q <= '0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_rise_s) begin
                        state_q     <= ST_PLAY;
                        health_q    <= HEALTH_LOAD;
                        score_q     <= '0;
                        update_en_q <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (|hit_vec) begin
                        if (health_q == HEALTH_ONE) begin
                            health_q    <= '0;
                            state_q     <= ST_OVER;
                            update_en_q <= 1'b0;
                            game_end_q  <= 1'b1;
                        end else begin
                            health_q  <= health_q - HEALTH_ONE;
                            inv_cnt_q <= INV_LOAD;
                            state_q   <= ST_HIT;
                            invuln_q  <= 1'b1;
                        end
                    end else if (pause_rise_s) begin
                        state_q     <= ST_PAUSE;
                        update_en_q <= 1'b0;
                    end
                end
                ST_HIT: begin
                    if (frame_tick) begin
                        inv_cnt_q <= inv_cnt_q - INV_ONE;
                        if (inv_cnt_q == INV_ONE) begin
                            state_q  <= ST_PLAY;
                            invuln_q <= 1'b0;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (pause_rise_s) begin
                        state_q     <= ST_PLAY;
                        update_en_q <= 1'b1;
                    end
                end
                ST_OVER: begin
                    if (!start) begin
                        state_q    <= ST_IDLE;
                        game_end_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    update_en_q <= 1'b0;
                    invuln_q    <= 1'b0;
                    game_end_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef HIGH_SCORE_EN
    logic [SCORE_W-1:0] high_score_q;

    // Best score captured on OVER entry, including the final cycle's kills
    always_ff @(posedge clk) begin
        if (rst) begin
            high_score_q <= '0;
        end else if (over_entry_s && (score_d > high_score_q)) begin
            high_score_q <= score_d;
        end
    end

    assign high_score = high_score_q;
`else
    assign high_score = '0;
`endif

    assign state       = state_q;
    assign update_en   = update_en_q;
    assign invuln      = invuln_q;
    assign game_end    = game_end_q;
    assign health      = health_q;
    assign score       = score_q;
    assign respawn_vec = respawn_q;

endmodule
